alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control unit that drives the 16-bit ALU's opcode/operand inputs and consumes its result.
- Fetches 16-bit instruction words, reads a 4-entry register file, issues one ALU operation per instruction and writes results back.
- Performs data-memory access for LOAD/STR using the ALU-computed address. Sits between instruction memory, data memory and the ALU.

Parameters:
WIDTH, 16, datapath/register/address width (>=16; instructions always use bits [15:0] of instr_data)
NREGS, 4, register-file entries (fixed 4; 2-bit register fields)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin execution at pc=0; sampled in IDLE only
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when HALT retires
illegal  output  1  sticky; set on opcode 110, cleared by rst or accepted start
instr_req  output  1  instruction fetch request
instr_addr  output  WIDTH  current pc
instr_valid  input  1  instruction data valid, completes fetch
instr_data  input  WIDTH  instruction word
alu_opcode  output  3  ALU opcode = ir[15:13]
alu_a  output  WIDTH  rf[ir[10:9]]
alu_b  output  WIDTH  rf[ir[8:7]]
alu_result  input  WIDTH  combinational ALU result
mem_req  output  1  data-memory request
mem_we  output  1  1 = store, 0 = load
mem_addr  output  WIDTH  registered ALU result
mem_wdata  output  WIDTH  rf[rd] for stores
mem_ack  input  1  completes data access
mem_rdata  input  WIDTH  load data, valid with mem_ack

Behaviour:
- Reset (async, immediate): state=IDLE; pc, ir, all rf entries, mem_addr, mem_wdata = 0; busy, done, illegal, instr_req, mem_req, mem_we = 0.
- Instruction fields: op=[15:13], rd=[12:11], rs1=[10:9], rs2=[8:7], [6:0] ignored.
- Opcodes: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 LOAD, 101 STR, 110 illegal, 111 HALT.
- alu_opcode/alu_a/alu_b are combinational from ir and rf at all times. They are meaningful only in EXEC; the value after reset is opcode 000 with zero operands.
- IDLE: start=1 -> pc<=0, illegal<=0, go to FETCH. start is ignored in every other state.
- FETCH: instr_req=1, instr_addr=pc, both held until the instr_valid cycle. On that cycle ir<=instr_data[15:0] and the FSM goes to EXEC. Minimum fetch latency is 1 cycle.
- EXEC (exactly 1 cycle):
  - 000-011: rf[rd]<=alu_result; pc<=pc+1; go to FETCH.
  - 100/101: mem_addr<=alu_result (ALU adds rs1+rs2); mem_wdata<=rf[rd]; mem_we<=(op==101); go to MEM.
  - 110: illegal<=1; no rf write; pc<=pc+1; go to FETCH.
  - 111: done=1 for this cycle; pc unchanged; go to IDLE.
- MEM: mem_req=1; mem_addr, mem_wdata and mem_we are held stable until the mem_ack cycle. On ack: a LOAD writes rf[rd]<=mem_rdata; then pc<=pc+1 and the FSM goes to FETCH. mem_req drops the cycle after ack.
- Instruction timing: ALU ops take 1 fetch cycle + 1 EXEC cycle minimum; memory ops take one more cycle plus ack latency.
- Arithmetic is performed entirely by the ALU. The sequencer never alters results: SUB wraps mod 2^WIDTH, DIV by zero yields 0, MUL yields the low WIDTH bits.
- pc wraps from 2^WIDTH-1 to 0 with no flag.
- rd may equal rs1/rs2. Operands are read before the write in the same EXEC cycle, so old values are used.
- r0 is an ordinary writable register.
- instr_valid/mem_ack asserted outside FETCH/MEM is ignored.
- Reset during FETCH/MEM drops instr_req/mem_req asynchronously; no rf write occurs.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: opcode 110 sets illegal, does not advance pc, pulses done and returns to IDLE (halts at the faulting pc).
- Undefined: opcode 110 executes as a NOP with sticky illegal set and execution continues.

Test Plan:
- Program `LOAD r1,[r0+r0]; LOAD r2,[r1+r0]; ADD r3,r1,r2; STR r3,[r1+r1]; HALT` with mem[0]=1, mem[1]=7 -> store at mem_addr=2, mem_wdata=8; done pulses once; busy=0; pc=4.
- r1=1, r2=7, then `SUB r3,r1,r2; STR r3,[r0+r0]` -> mem_wdata=0xFFFA. `MUL` with r1=0x0100, r2=0x0100 -> 0x0000.
- `DIV r3,r2,r0` with r2=7, r0=0 -> r3=0, confirmed by store. `ADD r1,r1,r1` with r1=3 -> r1=6.
- instr_valid delayed 3 cycles and mem_ack delayed 2 cycles -> instr_req/mem_req held high with instr_addr, mem_addr and mem_wdata stable throughout; no duplicate writes.
- Opcode 110 word 0xC000 at pc=5 -> illegal=1 and the next fetch is pc=6. With ILLEGAL_TRAP_EN: done pulses, busy=0, pc=5.
- rst asserted mid-MEM with mem_req=1 -> mem_req, busy and all registers at 0 before the next clock edge; a later start refetches from pc=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/exec/mem control unit driving an external 16-bit ALU.
// Latency: ALU op = fetch (>=1 cycle) + 1 EXEC cycle; LOAD/STR add MEM (>=1 cycle until mem_ack).
// Backpressure: instr_req/mem_req and their address/data are held until instr_valid/mem_ack.
// Optional feature: define ILLEGAL_TRAP_EN to halt (done pulse, pc kept) on opcode 110.
module alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             instr_req,
  output logic [WIDTH-1:0] instr_addr,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] instr_data,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_MEM   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_STR  = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] pc;
  logic [15:0]      ir;
  logic [WIDTH-1:0] rf [NREGS];

  logic [2:0] fetched_op;
  logic       fetch_ends_run;
  logic       unused_bits;

  // Decoded fields of the current instruction drive the ALU directly.
  assign alu_opcode = ir[15:13];
  assign alu_a      = rf[ir[10:9]];
  assign alu_b      = rf[ir[8:7]];
  assign instr_addr = pc;

  // done is registered, so it is decided as the word is fetched and lands in EXEC.
  assign fetched_op = instr_data[15:13];
`ifdef ILLEGAL_TRAP_EN
  assign fetch_ends_run = (fetched_op == OP_HALT) || (fetched_op == OP_ILL);
`else
  assign fetch_ends_run = (fetched_op == OP_HALT);
`endif

  // Operand-free instruction bits and any bits above 15 carry no meaning here.
  assign unused_bits = ^{instr_data, ir[6:0]};

  // Single control FSM: sequencing, register file, pc and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= '0;
      ir        <= '0;
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_req   <= 1'b0;
      instr_req <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc        <= '0;
            illegal   <= 1'b0;
            busy      <= 1'b1;
            instr_req <= 1'b1;
            state     <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (instr_valid) begin
            ir        <= instr_data[15:0];
            instr_req <= 1'b0;
            done      <= fetch_ends_run;
            state     <= S_EXEC;
          end
        end

        S_EXEC: begin
          case (ir[15:13])
            OP_LOAD, OP_STR: begin
              // ALU is presented rs1+rs2 as an ADD-class op and yields the address.
              mem_addr  <= alu_result;
              mem_wdata <= rf[ir[12:11]];
              mem_we    <= ir[13];
              mem_req   <= 1'b1;
              state     <= S_MEM;
            end
            OP_ILL: begin
              illegal <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
              busy    <= 1'b0;
              state   <= S_IDLE;
`else
              pc        <= pc + PC_STEP;
              instr_req <= 1'b1;
              state     <= S_FETCH;
`endif
            end
            OP_HALT: begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
            default: begin
              // ADD/SUB/MUL/DIV: result taken from the ALU unmodified.
              rf[ir[12:11]] <= alu_result;
              pc            <= pc + PC_STEP;
              instr_req     <= 1'b1;
              state         <= S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          if (mem_ack) begin
            if (!mem_we) rf[ir[12:11]] <= mem_rdata;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            pc        <= pc + PC_STEP;
            instr_req <= 1'b1;
            state     <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random programs and directed cases against an instruction-level model.
// Bench supplies the ALU, instruction memory and data memory with programmable latency.
// Defining ILLEGAL_TRAP_EN switches the model to trapping on opcode 110.
module tb_alu_sequencer;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, illegal, instr_req, instr_valid;
  logic [15:0] instr_addr, instr_data;
  logic [2:0]  alu_opcode;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(16), .NREGS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .illegal(illegal),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid),
    .instr_data(instr_data), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Behavioural ALU; LOAD/STR opcodes compute rs1+rs2.
  always_comb begin
    case (alu_opcode)
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a * alu_b;
      3'd3:    alu_result = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
      default: alu_result = alu_a + alu_b;
    endcase
  end

  logic [15:0] imem [64];
  logic [15:0] dmem [64];
  logic [15:0] mdl_mem [64];
  logic [15:0] mdl_rf [4];
  logic [15:0] obs_fetch[$], exp_fetch[$];
  logic [32:0] obs_mem[$], exp_mem[$];
  int idelay, mdelay, done_cnt;
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int rs2);
    logic [2:0] o; logic [1:0] d, s1, s2;
    o = op[2:0]; d = rd[1:0]; s1 = rs1[1:0]; s2 = rs2[1:0];
    return {o, d, s1, s2, 7'd0};
  endfunction

  function automatic logic [32:0] qm(input int i);
    if (i < obs_mem.size()) return obs_mem[i];
    return 'x;
  endfunction

  function automatic logic [32:0] qf(input int i);
    if (i < obs_fetch.size()) return {17'd0, obs_fetch[i]};
    return 'x;
  endfunction

  // Instruction-level reference: executes the program straight from the ISA rules.
  task automatic model_run(output int fin_pc, output bit ill);
    logic [15:0] pc, w, a, b, addr;
    logic [2:0]  op;
    logic [1:0]  rd, rs1, rs2;
    pc = 16'd0; ill = 1'b0; fin_pc = 0;
    exp_fetch.delete(); exp_mem.delete();
    for (int i = 0; i < 64; i++) mdl_mem[i] = dmem[i];
    for (int step = 0; step < 500; step++) begin
      exp_fetch.push_back(pc);
      w = imem[pc[5:0]];
      op = w[15:13]; rd = w[12:11]; rs1 = w[10:9]; rs2 = w[8:7];
      a = mdl_rf[rs1]; b = mdl_rf[rs2]; addr = a + b;
      if (op == 3'd6) ill = 1'b1;
      if (op == 3'd7 || (op == 3'd6 && TRAP)) begin
        fin_pc = int'(pc);
        break;
      end
      case (op)
        3'd0: mdl_rf[rd] = a + b;
        3'd1: mdl_rf[rd] = a - b;
        3'd2: mdl_rf[rd] = a * b;
        3'd3: mdl_rf[rd] = (b == 16'd0) ? 16'd0 : a / b;
        3'd4: begin
          exp_mem.push_back({1'b0, addr, mdl_rf[rd]});
          mdl_rf[rd] = mdl_mem[addr[5:0]];
        end
        3'd5: begin
          exp_mem.push_back({1'b1, addr, mdl_rf[rd]});
          mdl_mem[addr[5:0]] = mdl_rf[rd];
        end
        default: ;
      endcase
      pc = pc + 16'd1;
    end
  endtask

  // Memory responders with latency, stability monitor and spurious handshakes.
  initial begin : responder
    int icnt, mcnt;
    logic [15:0] ia;
    logic [32:0] ma, cur;
    bit ichg, mchg;
    icnt = 0; mcnt = 0; ichg = 0; mchg = 0; ia = '0; ma = '0;
    forever begin
      @(negedge clk);
      instr_valid = 1'b0;
      mem_ack = 1'b0;
      if (done) done_cnt++;
      if (rst) begin
        icnt = 0; mcnt = 0; ichg = 0; mchg = 0;
      end else begin
        if (instr_req) begin
          if (icnt == 0) ia = instr_addr;
          else if (instr_addr !== ia) ichg = 1;
          if (icnt >= idelay) begin
            instr_valid = 1'b1;
            instr_data = imem[instr_addr[5:0]];
            obs_fetch.push_back(instr_addr);
            chk("fetch_stable", {32'd0, ichg}, 33'd0);
            icnt = 0; ichg = 0;
          end else icnt++;
        end else if ($urandom_range(0, 3) == 0) begin
          instr_valid = 1'b1;
          instr_data = 16'($urandom);
        end
        if (mem_req) begin
          cur = {mem_we, mem_addr, mem_wdata};
          if (mcnt == 0) ma = cur;
          else if (cur !== ma) mchg = 1;
          if (mcnt >= mdelay) begin
            mem_ack = 1'b1;
            obs_mem.push_back(cur);
            if (mem_we) dmem[mem_addr[5:0]] = mem_wdata;
            else mem_rdata = dmem[mem_addr[5:0]];
            chk("mem_stable", {32'd0, mchg}, 33'd0);
            mcnt = 0; mchg = 0;
          end else mcnt++;
        end else if ($urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = 16'($urandom);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) mdl_rf[i] = 16'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_prog(input string nm);
    int fin_pc, cyc;
    bit ill;
    model_run(fin_pc, ill);
    obs_fetch.delete(); obs_mem.delete(); done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_done_seen"}, {32'd0, (cyc < 4000)}, 33'd1);
    @(negedge clk);
    chk({nm, "_busy"}, {32'd0, busy}, 33'd0);
    chk({nm, "_done_cnt"}, 33'(done_cnt), 33'd1);
    chk({nm, "_illegal"}, {32'd0, illegal}, {32'd0, ill});
    chk({nm, "_pc"}, {17'd0, instr_addr}, 33'(fin_pc));
    chk({nm, "_nfetch"}, 33'(obs_fetch.size()), 33'(exp_fetch.size()));
    chk({nm, "_nmem"}, 33'(obs_mem.size()), 33'(exp_mem.size()));
    for (int i = 0; i < exp_fetch.size(); i++) chk({nm, "_fetch"}, qf(i), {17'd0, exp_fetch[i]});
    for (int i = 0; i < exp_mem.size(); i++) chk({nm, "_mem"}, qm(i), exp_mem[i]);
  endtask

  task automatic load_prog_a();
    for (int i = 0; i < 64; i++) imem[i] = 16'hE000;
    imem[0] = enc(4, 1, 0, 0);
    imem[1] = enc(4, 2, 1, 0);
    imem[2] = enc(0, 3, 1, 2);
    imem[3] = enc(5, 3, 1, 1);
    imem[4] = enc(7, 0, 0, 0);
    for (int i = 0; i < 64; i++) dmem[i] = 16'd0;
    dmem[0] = 16'd1; dmem[1] = 16'd7;
  endtask

  initial begin
    int n, cyc;
    rst = 1'b1; start = 1'b0; instr_valid = 1'b0; instr_data = '0;
    mem_ack = 1'b0; mem_rdata = '0; idelay = 0; mdelay = 0; done_cnt = 0;
    for (int i = 0; i < 4; i++) mdl_rf[i] = 16'd0;
    for (int i = 0; i < 64; i++) begin imem[i] = 16'hE000; dmem[i] = 16'd0; end
    #12;
    chk("rst_ctrl", {27'd0, busy, done, illegal, instr_req, mem_req, mem_we}, 33'd0);
    chk("rst_pc", {17'd0, instr_addr}, 33'd0);
    chk("rst_mem", {1'b0, mem_addr, mem_wdata}, 33'd0);
    chk("rst_aluop", {30'd0, alu_opcode}, 33'd0);
    chk("rst_aluab", {1'b0, alu_a, alu_b}, 33'd0);
    @(negedge clk); rst = 1'b0;

    // Directed load/add/store program.
    load_prog_a();
    run_prog("progA");
    chk("progA_store", qm(2), {1'b1, 16'd2, 16'd8});
    chk("progA_pc4", {17'd0, instr_addr}, 33'd4);

    // Same program with slow fetch and slow memory.
    do_reset();
    load_prog_a();
    idelay = 3; mdelay = 2;
    run_prog("progA_slow");
    chk("progA_slow_store", qm(2), {1'b1, 16'd2, 16'd8});

    // Reset while a load is outstanding.
    do_reset();
    load_prog_a();
    idelay = 0; mdelay = 6;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 50) begin @(negedge clk); cyc++; end
    chk("mid_mem_reached", {32'd0, mem_req}, 33'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", {29'd0, busy, mem_req, instr_req, mem_we}, 33'd0);
    chk("mid_rst_regs", {1'b0, mem_addr, instr_addr}, 33'd0);
    for (int i = 0; i < 4; i++) mdl_rf[i] = 16'd0;
    @(negedge clk); rst = 1'b0;
    mdelay = 1;
    run_prog("progA_after_rst");

    // SUB wrap, DIV by zero, illegal opcode at pc=5, rd==rs, MUL truncation.
    do_reset();
    for (int i = 0; i < 64; i++) begin imem[i] = 16'hE000; dmem[i] = 16'd0; end
    dmem[0] = 16'd1; dmem[1] = 16'd7; dmem[4] = 16'h0100;
    imem[0]  = enc(4, 1, 0, 0);
    imem[1]  = enc(4, 2, 1, 0);
    imem[2]  = enc(1, 3, 1, 2);
    imem[3]  = enc(5, 3, 0, 0);
    imem[4]  = enc(3, 3, 2, 0);
    imem[5]  = 16'hC000;
    imem[6]  = enc(5, 3, 1, 1);
    imem[7]  = enc(0, 1, 1, 1);
    imem[8]  = enc(5, 1, 0, 0);
    imem[9]  = enc(4, 2, 1, 1);
    imem[10] = enc(2, 3, 2, 2);
    imem[11] = enc(5, 3, 2, 0);
    imem[12] = enc(7, 0, 0, 0);
    idelay = 1; mdelay = 0;
    run_prog("progB");
    chk("progB_sub_wrap", qm(2), {1'b1, 16'd0, 16'hFFFA});
    chk("progB_illegal", {32'd0, illegal}, 33'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("progB_trap_pc", {17'd0, instr_addr}, 33'd5);
    chk("progB_trap_nmem", 33'(obs_mem.size()), 33'd3);
`else
    chk("progB_div0", qm(3), {1'b1, 16'd2, 16'd0});
    chk("progB_after_ill", qf(6), 33'd6);
    chk("progB_rd_eq_rs", qm(4), {1'b1, 16'd0, 16'd2});
    chk("progB_mul", qm(6), {1'b1, 16'h0100, 16'd0});
`endif

    // Random programs; the first follows progB without reset so illegal must clear on start.
    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 1) do_reset();
      for (int i = 0; i < 64; i++) begin
        imem[i] = 16'hE000;
        dmem[i] = 16'($urandom_range(0, 15));
      end
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++)
        imem[i] = enc($urandom_range(0, (r == 0) ? 5 : 6), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
      idelay = $urandom_range(0, 3);
      mdelay = $urandom_range(0, 3);
      run_prog($sformatf("rand%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
